mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit: the consumer of the E->M pipeline register outputs (mem_we_m, mem_type_m, alu_result_m, rd2_m).
Converts one M-stage access into a req/ack data-bus transaction and stalls the pipeline until the transaction completes.
Generates byte strobes and store-data lane placement, and returns load data sign- or zero-extended for writeback.
Flags misaligned accesses and bus timeouts without issuing or completing a transfer.

Parameters:
TIMEOUT, 16, max cycles bus_req may stay high without bus_ack before aborting (range 2..255)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  suppresses starting a new access this cycle
mem_re_m  input  1  M-stage load request
mem_we_m  input  1  M-stage store request
mem_type_m  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_result_m  input  32  byte address
rd2_m  input  32  store data (low-aligned)
stall  output  1  hold pipeline (combinational)
load_data  output  32  extended load result, valid when load_valid
load_valid  output  1  one-cycle pulse at load completion
misalign  output  1  one-cycle pulse, access not issued
bus_err  output  1  one-cycle pulse on timeout
bus_req  output  1  transaction request
bus_we  output  1  1 = write
bus_addr  output  32  word address (addr[1:0] forced 00)
bus_wstrb  output  4  byte strobes (0000 for reads)
bus_wdata  output  32  lane-shifted store data
bus_ack  input  1  completes transaction, same-cycle rdata
bus_rdata  input  32  read word

Behaviour:
- Reset: state IDLE, timeout counter 0; bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata, load_data, load_valid, misalign, bus_err all 0. Reset mid-transaction drops bus_req on the next edge; no pulse output is produced.
- access = (mem_re_m | mem_we_m) & ~flush. If both are high, the access is a store.
- aligned: B/BU always; H/HU when addr[0]=0; W when addr[1:0]=00. Undefined mem_type values (011, 110, 111) are treated as W.
- States: IDLE, REQ, DONE.
- IDLE, access & ~aligned: misalign pulses next cycle, stall=0, no bus activity, stay IDLE.
- IDLE, access & aligned: stall=1 combinationally. Register bus_addr, bus_we, bus_wstrb, bus_wdata; set bus_req=1; counter=0; go to REQ.
- REQ: stall=1; bus outputs held stable.
  - bus_ack=1: drop bus_req. On a read, capture the extended load into load_data. Go to DONE.
  - Otherwise counter increments. When counter reaches TIMEOUT-1 without ack: drop bus_req, pulse bus_err, set load_data=0, go to DONE.
  - flush is ignored in REQ.
- DONE: stall=0. load_valid=1 for this cycle only, for reads including timed-out reads. Return to IDLE.
- A new access may not start in DONE, because the pipeline advances this cycle.
- Minimum latency with ack in the first REQ cycle: 2 stall cycles.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0]; wdata = {4{rd2[7:0]}}.
  - SH: wstrb = 0011<<addr[1:0]; wdata = {2{rd2[15:0]}}.
  - SW: wstrb = 1111; wdata = rd2.
- Load extraction: select the byte or halfword by addr[1:0], then sign-extend (B/H) or zero-extend (BU/HU); W is passed unchanged.
- bus_ack outside REQ is ignored.

Test Plan:
- Reset with bus_req high in REQ -> next cycle bus_req=0, stall=0, load_valid=0, state IDLE.
- LB addr 0x1003, bus_rdata 0x80FF_1234, ack in the first REQ cycle -> bus_addr 0x1000, wstrb 0000, stall high 2 cycles, load_data 0xFFFF_FF80, load_valid one-cycle pulse.
- LHU addr 0x2002, rdata 0x9ABC_5678 -> load_data 0x0000_9ABC; LH at the same address -> 0xFFFF_9ABC.
- SB addr 0x3001, rd2 0x1122_33A5 -> bus_we=1, wstrb 0010, wdata 0xA5A5_A5A5; SH addr 0x3002 -> wstrb 1100, wdata 0x33A5_33A5.
- LW addr 0x4002 -> misalign pulse, bus_req never asserted, stall never asserted; SH addr 0x4001 -> same result.
- LW with ack withheld, TIMEOUT=16 -> bus_req high exactly 16 cycles, bus_err pulse, load_valid with load_data 0; also cover mem_re_m=mem_we_m=1 issuing a store, and flush=1 in IDLE issuing no access.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit driving a req/ack data bus.
// Stalls the pipeline for the bus transaction and returns extended load data.
module mem_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_re_m,
    input  logic        mem_we_m,
    input  logic [2:0]  mem_type_m,
    input  logic [31:0] alu_result_m,
    input  logic [31:0] rd2_m,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  count;
    logic [2:0]  type_q;
    logic [1:0]  lo_q;
    logic        access, is_b, is_h, aligned, start, bad, timeout_hit;
    logic [3:0]  strb;
    logic [31:0] wdata, shifted, ext;

    // Low funct3 bits pick the size; anything not B or H behaves as a word.
    assign access      = (mem_re_m | mem_we_m) & ~flush;
    assign is_b        = mem_type_m[1:0] == 2'b00;
    assign is_h        = mem_type_m[1:0] == 2'b01;
    assign aligned     = is_b | (is_h & ~alu_result_m[0]) | (alu_result_m[1:0] == 2'b00);
    assign start       = (state == IDLE) & access & aligned;
    assign bad         = (state == IDLE) & access & ~aligned;
    assign timeout_hit = (state == REQ) & ~bus_ack & (count == 8'(TIMEOUT - 1));

    assign strb  = is_b ? 4'b0001 << alu_result_m[1:0] : is_h ? 4'b0011 << alu_result_m[1:0] : 4'b1111;
    assign wdata = is_b ? {4{rd2_m[7:0]}} : is_h ? {2{rd2_m[15:0]}} : rd2_m;

    assign shifted = bus_rdata >> {lo_q, 3'b000};
    assign ext = type_q[1:0] == 2'b00 ? {{24{shifted[7] & ~type_q[2]}}, shifted[7:0]} :
                 type_q[1:0] == 2'b01 ? {{16{shifted[15] & ~type_q[2]}}, shifted[15:0]} :
                 bus_rdata;

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        state_next = state == IDLE ? (start ? REQ : IDLE) :
                     state == REQ  ? ((bus_ack | timeout_hit) ? DONE : REQ) : IDLE;
        stall      = start | (state == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            type_q     <= '0;
            lo_q       <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wstrb  <= '0;
            bus_wdata  <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            misalign   <= bad;
            bus_err    <= timeout_hit;
            load_valid <= (state == REQ) & ~bus_we & (bus_ack | timeout_hit);
            if (start) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_we_m;
                bus_addr  <= {alu_result_m[31:2], 2'b00};
                bus_wstrb <= mem_we_m ? strb : 4'b0000;
                bus_wdata <= mem_we_m ? wdata : 32'h0;
                type_q    <= mem_type_m;
                lo_q      <= alu_result_m[1:0];
                count     <= '0;
            end
            if (state == REQ) begin
                if (bus_ack) begin
                    bus_req <= 1'b0;
                    if (!bus_we)
                        load_data <= ext;
                end else if (timeout_hit) begin
                    bus_req   <= 1'b0;
                    load_data <= '0;
                end else begin
                    count <= count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized transactions against a byte-lane
// reference model of the load/store unit.
module tb_mem_stage_lsu;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst, flush, mem_re_m, mem_we_m, bus_ack;
    logic [2:0]  mem_type_m;
    logic [31:0] alu_result_m, rd2_m, bus_rdata;
    logic        stall, load_valid, misalign, bus_err, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_ld;

    mem_stage_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_re_m(mem_re_m), .mem_we_m(mem_we_m),
        .mem_type_m(mem_type_m), .alu_result_m(alu_result_m), .rd2_m(rd2_m),
        .stall(stall), .load_data(load_data), .load_valid(load_valid), .misalign(misalign),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] t);
        return (t == 3'd0 || t == 3'd4) ? 1 : (t == 3'd1 || t == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int sz);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [2:0] t, input int lo);
        logic [31:0] v;
        int sz;
        sz = size_of(t);
        v = rd >> (8 * lo);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (t == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic txn(input logic re, input logic we, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d, input int ack_at, input logic [31:0] rdata);
        int sz, lo, n;
        logic ok, timed, is_ld;
        logic [3:0] strb;
        sz    = size_of(t);
        lo    = int'(a[1:0]);
        ok    = (lo % sz) == 0;
        is_ld = re & ~we;
        strb  = we ? 4'(((1 << sz) - 1) << lo) : 4'b0000;
        @(negedge clk);
        mem_re_m = re; mem_we_m = we; mem_type_m = t; alu_result_m = a; rd2_m = d; flush = 1'b0;
        #1 check("stall_start", {31'b0, stall}, {31'b0, ok});
        @(posedge clk); #1;
        mem_re_m = 1'b0; mem_we_m = 1'b0;
        if (!ok) begin
            check("misalign_pulse", {31'b0, misalign}, 32'd1);
            check("misalign_noreq", {31'b0, bus_req}, 32'd0);
            check("misalign_nostall", {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
            check("misalign_clear", {31'b0, misalign}, 32'd0);
            check("misalign_noreq2", {31'b0, bus_req}, 32'd0);
            return;
        end
        check("req", {31'b0, bus_req}, 32'd1);
        check("addr", bus_addr, {a[31:2], 2'b00});
        check("we", {31'b0, bus_we}, {31'b0, we});
        check("wstrb", {28'b0, bus_wstrb}, {28'b0, strb});
        if (we) check("wdata", bus_wdata, model_wdata(d, sz));
        check("no_misalign", {31'b0, misalign}, 32'd0);
        n = 0;
        while (bus_req && n < TO + 8) begin
            check("stall_req", {31'b0, stall}, 32'd1);
            bus_ack   = (n == ack_at);
            bus_rdata = (n == ack_at) ? rdata : $urandom;
            @(posedge clk); #1;
            bus_ack = 1'b0;
            n++;
        end
        timed = !(ack_at >= 0 && ack_at < TO);
        check("req_cycles", 32'(n), timed ? 32'(TO) : 32'(ack_at + 1));
        check("stall_done", {31'b0, stall}, 32'd0);
        check("load_valid", {31'b0, load_valid}, {31'b0, is_ld});
        check("bus_err", {31'b0, bus_err}, {31'b0, timed});
        if (is_ld) check("load_data", load_data, timed ? 32'h0 : model_load(rdata, t, lo));
        last_ld = load_data;
        @(posedge clk); #1;
        check("lv_clear", {31'b0, load_valid}, 32'd0);
        check("err_clear", {31'b0, bus_err}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_re_m = 1'b0; mem_we_m = 1'b0; mem_type_m = 3'd0;
        alu_result_m = '0; rd2_m = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'b0, bus_req}, 32'd0);
        check("rst_we", {31'b0, bus_we}, 32'd0);
        check("rst_wstrb", {28'b0, bus_wstrb}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_ld", load_data, 32'd0);
        check("rst_lv", {31'b0, load_valid}, 32'd0);
        check("rst_mis", {31'b0, misalign}, 32'd0);
        check("rst_err", {31'b0, bus_err}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        @(negedge clk); rst = 1'b0;

        @(negedge clk);
        mem_re_m = 1'b1; mem_type_m = 3'd2; alu_result_m = 32'h100;
        @(posedge clk); #1;
        mem_re_m = 1'b0;
        check("midrst_req", {31'b0, bus_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_req_drop", {31'b0, bus_req}, 32'd0);
        check("midrst_stall", {31'b0, stall}, 32'd0);
        check("midrst_lv", {31'b0, load_valid}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_lv2", {31'b0, load_valid}, 32'd0);
        check("midrst_err", {31'b0, bus_err}, 32'd0);
        check("midrst_idle", {31'b0, bus_req}, 32'd0);

        txn(1, 0, 3'd0, 32'h1003, 32'h0, 0, 32'h80FF_1234);
        check("lb_const", last_ld, 32'hFFFF_FF80);
        txn(1, 0, 3'd5, 32'h2002, 32'h0, 1, 32'h9ABC_5678);
        check("lhu_const", last_ld, 32'h0000_9ABC);
        txn(1, 0, 3'd1, 32'h2002, 32'h0, 2, 32'h9ABC_5678);
        check("lh_const", last_ld, 32'hFFFF_9ABC);
        txn(0, 1, 3'd0, 32'h3001, 32'h1122_33A5, 0, 32'h0);
        txn(0, 1, 3'd1, 32'h3002, 32'h1122_33A5, 0, 32'h0);
        txn(1, 0, 3'd2, 32'h4002, 32'h0, 0, 32'h0);
        txn(0, 1, 3'd1, 32'h4001, 32'h5555_AAAA, 0, 32'h0);
        txn(1, 0, 3'd2, 32'h5000, 32'h0, -1, 32'h0);
        check("lw_timeout_zero", last_ld, 32'h0);
        txn(0, 1, 3'd2, 32'h5004, 32'h0BAD_F00D, TO - 1, 32'h0);
        txn(1, 1, 3'd2, 32'h6000, 32'hDEAD_BEEF, 0, 32'h0);
        txn(1, 0, 3'd7, 32'h7004, 32'h0, 0, 32'hCAFE_0001);

        @(negedge clk);
        mem_re_m = 1'b1; mem_type_m = 3'd2; alu_result_m = 32'h8002; flush = 1'b1;
        #1 check("flush_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        check("flush_noreq", {31'b0, bus_req}, 32'd0);
        check("flush_nomis", {31'b0, misalign}, 32'd0);
        mem_re_m = 1'b0; flush = 1'b0;

        for (int k = 0; k < 40; k++) begin
            int kind;
            kind = $urandom_range(0, 2);
            txn(kind != 1, kind != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
